// File: rtl/sequenciador_exibicao_pkg.sv
// Shared definitions for the sequence display block and the other ROM address generators.
package sequenciador_exibicao_pkg;

    localparam int LARGURA_DADO = 4;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        ENDERECA = 3'd1,
        CAPTURA  = 3'd2,
        MOSTRA   = 3'd3,
        APAGA    = 3'd4,
        FIM      = 3'd5
    } estado_t;

    // 2-to-4 one-hot decode used to address the one-hot ROM.
    function automatic logic [3:0] decodifica_one_hot(input logic [1:0] indice);
        logic [3:0] r;
        r = 4'b0000;
        r[indice] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/sequenciador_exibicao_if.sv
// Bus between the sequencer (master) and the game controller plus ROM (slave).
// Handshake: iniciar is a start request accepted only while idle (ativo=0);
// ativo stays high until the run ends, and pronto pulses for one cycle when a
// sequence completes. parar aborts a run without pronto.
interface sequenciador_exibicao_if;
    import sequenciador_exibicao_pkg::*;

    logic                    iniciar;
    logic                    parar;
    logic [1:0]              limite;
    logic [LARGURA_DADO-1:0] dados_rom;
    logic [3:0]              endereco;
    logic [LARGURA_DADO-1:0] leds;
    logic                    ativo;
    logic                    pronto;
    estado_t                 estado;

    modport master (
        input  iniciar, parar, limite, dados_rom,
        output endereco, leds, ativo, pronto, estado
    );

    modport slave (
        output iniciar, parar, limite, dados_rom,
        input  endereco, leds, ativo, pronto, estado
    );

endinterface

// File: rtl/sequenciador_exibicao_contador_duracao.sv
// Loadable down-counter that times the on and off intervals; stops at zero.
module contador_duracao #(
    parameter int W = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         carrega,
    input  logic [W-1:0] valor,
    output logic         zero
);

    logic [W-1:0] conta_q, conta_d;

    // Load has priority; otherwise count down and hold at zero.
    always_comb begin
        conta_d = conta_q;
        if (carrega) begin
            conta_d = valor;
        end else if (conta_q != '0) begin
            conta_d = conta_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) conta_q <= '0;
        else        conta_q <= conta_d;
    end

    assign zero = (conta_q == '0);

endmodule

// File: rtl/sequenciador_exibicao.sv
// Walks the one-hot ROM from step 0 up to limite, showing each word on leds
// for ON_CYCLES and blanking for OFF_CYCLES, then pulses pronto.
module sequenciador_exibicao
    import sequenciador_exibicao_pkg::*;
#(
    parameter int ON_CYCLES  = 4,
    parameter int OFF_CYCLES = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    sequenciador_exibicao_if.master  bus
);

    localparam int MAX_CICLOS = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int CW         = (MAX_CICLOS > 1) ? $clog2(MAX_CICLOS) : 1;

    estado_t                 estado_q, estado_d;
    logic [1:0]              indice_q, indice_d;
    logic [1:0]              limite_q, limite_d;
    logic [LARGURA_DADO-1:0] leds_q, leds_d;
    logic                    carrega;
    logic [CW-1:0]           valor;
    logic                    zero;

    // One shared timer serves both the on and the off interval.
    contador_duracao #(.W(CW)) u_contador (
        .clock   (clock),
        .reset   (reset),
        .carrega (carrega),
        .valor   (valor),
        .zero    (zero)
    );

    // Next-state logic; parar overrides everything while a run is active.
    always_comb begin
        estado_d = estado_q;
        indice_d = indice_q;
        limite_d = limite_q;
        leds_d   = leds_q;
        carrega  = 1'b0;
        valor    = '0;
        if (estado_q != OCIOSO && bus.parar) begin
            estado_d = OCIOSO;
            leds_d   = '0;
            indice_d = 2'd0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (bus.iniciar && !bus.parar) begin
                        indice_d = 2'd0;
                        limite_d = bus.limite;
                        estado_d = ENDERECA;
                    end
                end
                ENDERECA: estado_d = CAPTURA;
                CAPTURA: begin
                    leds_d   = bus.dados_rom;
                    carrega  = 1'b1;
                    valor    = CW'(ON_CYCLES - 1);
                    estado_d = MOSTRA;
                end
                MOSTRA: begin
                    if (zero) begin
                        leds_d   = '0;
                        carrega  = 1'b1;
                        valor    = CW'(OFF_CYCLES - 1);
                        estado_d = APAGA;
                    end
                end
                APAGA: begin
                    if (zero) begin
                        if (indice_q == limite_q) begin
                            estado_d = FIM;
                        end else begin
                            indice_d = indice_q + 2'd1;
                            estado_d = ENDERECA;
                        end
                    end
                end
                FIM:     estado_d = OCIOSO;
                default: estado_d = OCIOSO;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= OCIOSO;
            indice_q <= 2'd0;
            limite_q <= 2'd0;
            leds_q   <= '0;
        end else begin
            estado_q <= estado_d;
            indice_q <= indice_d;
            limite_q <= limite_d;
            leds_q   <= leds_d;
        end
    end

    // Address is only driven while a step is in progress.
    always_comb begin
        bus.endereco = 4'b0000;
        if (estado_q == ENDERECA || estado_q == CAPTURA ||
            estado_q == MOSTRA   || estado_q == APAGA) begin
            bus.endereco = decodifica_one_hot(indice_q);
        end
    end

    assign bus.leds   = leds_q;
    assign bus.ativo  = (estado_q != OCIOSO);
    assign bus.pronto = (estado_q == FIM);
    assign bus.estado = estado_q;

endmodule
